// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encoding, MIPS opcode/funct constants and the decoded
// issue record shared by the issue controller, its decoder and the ALU.
`default_nettype none

package alu_pkg;

   localparam logic [4:0] ALU_SLL  = 5'd0;
   localparam logic [4:0] ALU_SRL  = 5'd1;
   localparam logic [4:0] ALU_SRA  = 5'd2;
   localparam logic [4:0] ALU_SLLV = 5'd3;
   localparam logic [4:0] ALU_SRLV = 5'd4;
   localparam logic [4:0] ALU_SRAV = 5'd5;
   localparam logic [4:0] ALU_ADD  = 5'd6;
   localparam logic [4:0] ALU_ADDU = 5'd7;
   localparam logic [4:0] ALU_SUB  = 5'd8;
   localparam logic [4:0] ALU_SUBU = 5'd9;
   localparam logic [4:0] ALU_AND  = 5'd10;
   localparam logic [4:0] ALU_OR   = 5'd11;
   localparam logic [4:0] ALU_XOR  = 5'd12;
   localparam logic [4:0] ALU_NOR  = 5'd13;
   localparam logic [4:0] ALU_SLT  = 5'd14;
   localparam logic [4:0] ALU_SLTU = 5'd15;
   localparam logic [4:0] ALU_LUI  = 5'd16;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef struct packed {
      logic [4:0]  code;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  shamt;
      logic [4:0]  dest;
      logic        ri;
   } dec_t;

   // Only the trapping arithmetic codes may raise an overflow exception.
   function automatic logic is_trap_code(input logic [4:0] code);
      return (code == ALU_ADD) || (code == ALU_SUB);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational MIPS opcode/funct decode into the ALU
// control code, operands, shift amount, destination and reserved flag.
`default_nettype none

module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output dec_t        dec
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        unused_rs_field;

   assign opcode          = instr[31:26];
   assign funct           = instr[5:0];
   assign imm_sext        = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext        = {16'b0, instr[15:0]};
   assign unused_rs_field = ^instr[25:21];

   always_comb begin
      dec    = '0;
      dec.ri = 1'b1;
      if (opcode == OP_RTYPE) begin
         dec.ri    = 1'b0;
         dec.dest  = instr[15:11];
         dec.shamt = instr[10:6];
         dec.rs    = rs_val;
         dec.rt    = rt_val;
         case (funct)
            F_SLL:  dec.code = ALU_SLL;
            F_SRL:  dec.code = ALU_SRL;
            F_SRA:  dec.code = ALU_SRA;
            // The ALU shifts by the whole rs value, so clip it to 0..31 here.
            F_SLLV: begin dec.code = ALU_SLLV; dec.rs = {27'b0, rs_val[4:0]}; end
            F_SRLV: begin dec.code = ALU_SRLV; dec.rs = {27'b0, rs_val[4:0]}; end
            F_SRAV: begin dec.code = ALU_SRAV; dec.rs = {27'b0, rs_val[4:0]}; end
            F_ADD:  dec.code = ALU_ADD;
            F_ADDU: dec.code = ALU_ADDU;
            F_SUB:  dec.code = ALU_SUB;
            F_SUBU: dec.code = ALU_SUBU;
            F_AND:  dec.code = ALU_AND;
            F_OR:   dec.code = ALU_OR;
            F_XOR:  dec.code = ALU_XOR;
            F_NOR:  dec.code = ALU_NOR;
            F_SLT:  dec.code = ALU_SLT;
            F_SLTU: dec.code = ALU_SLTU;
            default: begin
               dec    = '0;
               dec.ri = 1'b1;
            end
         endcase
      end else begin
         dec.ri   = 1'b0;
         dec.dest = instr[20:16];
         dec.rs   = rs_val;
         dec.rt   = imm_sext;
         case (opcode)
            OP_ADDI:  dec.code = ALU_ADD;
            OP_ADDIU: dec.code = ALU_ADDU;
            OP_SLTI:  dec.code = ALU_SLT;
            OP_SLTIU: dec.code = ALU_SLTU;
            OP_ANDI:  begin dec.code = ALU_AND; dec.rt = imm_zext; end
            OP_ORI:   begin dec.code = ALU_OR;  dec.rt = imm_zext; end
            OP_XORI:  begin dec.code = ALU_XOR; dec.rt = imm_zext; end
            OP_LUI:   begin dec.code = ALU_LUI; dec.rt = imm_zext; end
            default: begin
               dec    = '0;
               dec.ri = 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage issue/retire controller; stage 1 drives the ALU
// inputs, stage 2 holds the writeback record with exception flags.
`default_nettype none

module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter bit OVF_TRAP     = 1'b1,
   parameter bit ZERO_DEST_WE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] alu_rs,
   output logic [31:0] alu_rt,
   output logic [4:0]  alu_control,
   output logic [4:0]  shamt,
   input  logic [31:0] alu_out,
   input  logic        overflow,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_dest,
   output logic        wb_we,
   output logic        exc_ovf,
   output logic        exc_ri
);

   dec_t       dec;
   logic       s1_valid;
   logic       s2_valid;
   logic       s2_free;
   logic       s1_adv;
   logic       accept;
   logic [4:0] s1_dest;
   logic       s1_ri;
   logic       ovf;

   alu_issue_decode u_decode (
      .instr  (instr),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .dec    (dec)
   );

   assign s2_free  = !s2_valid | wb_ready;
   assign s1_adv   = s1_valid & s2_free;
   assign in_ready = !s1_valid | s1_adv;
   assign accept   = in_valid & in_ready;
   assign wb_valid = s2_valid;
   assign ovf      = overflow & OVF_TRAP & is_trap_code(alu_control);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         alu_rs      <= '0;
         alu_rt      <= '0;
         alu_control <= '0;
         shamt       <= '0;
         s1_dest     <= '0;
         s1_ri       <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid    <= 1'b1;
            alu_rs      <= dec.rs;
            alu_rt      <= dec.rt;
            alu_control <= dec.code;
            shamt       <= dec.shamt;
            s1_dest     <= dec.dest;
            s1_ri       <= dec.ri;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // The record only changes on an advance, so it stays put while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         wb_data  <= '0;
         wb_dest  <= '0;
         wb_we    <= 1'b0;
         exc_ovf  <= 1'b0;
         exc_ri   <= 1'b0;
      end else if (s1_adv) begin
         s2_valid <= 1'b1;
         wb_data  <= alu_out;
         wb_dest  <= s1_dest;
         wb_we    <= !s1_ri & !ovf & (ZERO_DEST_WE | (s1_dest != 5'd0));
         exc_ovf  <= ovf;
         exc_ri   <= s1_ri;
      end else if (wb_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural
// ALU; a second instance runs with OVF_TRAP=0 and ZERO_DEST_WE=1.
`default_nettype none

module tb_alu_issue_ctrl;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  dest;
      logic        we;
      logic        ovf;
      logic        ri;
      logic        we_nt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        wb_ready;
   logic [31:0] instr;
   logic [31:0] rs_val;
   logic [31:0] rt_val;

   logic        in_ready, wb_valid, wb_we, exc_ovf, exc_ri, overflow;
   logic [31:0] alu_rs, alu_rt, alu_out, wb_data;
   logic [4:0]  alu_control, shamt, wb_dest;

   logic        nt_in_ready, nt_wb_valid, nt_wb_we, nt_exc_ovf, nt_exc_ri, nt_overflow;
   logic [31:0] nt_alu_rs, nt_alu_rt, nt_alu_out, nt_wb_data;
   logic [4:0]  nt_alu_control, nt_shamt, nt_wb_dest;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_control(alu_control), .shamt(shamt),
      .alu_out(alu_out), .overflow(overflow),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
      .wb_we(wb_we), .exc_ovf(exc_ovf), .exc_ri(exc_ri)
   );

   alu_issue_ctrl #(.OVF_TRAP(1'b0), .ZERO_DEST_WE(1'b1)) dut_nt (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nt_in_ready),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_rs(nt_alu_rs), .alu_rt(nt_alu_rt), .alu_control(nt_alu_control), .shamt(nt_shamt),
      .alu_out(nt_alu_out), .overflow(nt_overflow),
      .wb_valid(nt_wb_valid), .wb_ready(wb_ready), .wb_data(nt_wb_data), .wb_dest(nt_wb_dest),
      .wb_we(nt_wb_we), .exc_ovf(nt_exc_ovf), .exc_ri(nt_exc_ri)
   );

   // Behavioural ALU; its flag is raised for any signed wrap of the adder,
   // including the unsigned variants, so the controller must filter by code.
   function automatic logic [32:0] alu_model(input logic [4:0] code, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] r;
      logic        v;
      r = '0;
      v = 1'b0;
      case (code)
         5'd0:  r = b << sh;
         5'd1:  r = b >> sh;
         5'd2:  r = 32'($signed(b) >>> sh);
         5'd3:  r = b << a;
         5'd4:  r = b >> a;
         5'd5:  r = 32'($signed(b) >>> a);
         5'd6, 5'd7: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         5'd8, 5'd9: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         5'd10: r = a & b;
         5'd11: r = a | b;
         5'd12: r = a ^ b;
         5'd13: r = ~(a | b);
         5'd14: r = {31'b0, $signed(a) < $signed(b)};
         5'd15: r = {31'b0, a < b};
         5'd16: r = b << 16;
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   always_comb {overflow, alu_out}       = alu_model(alu_control, alu_rs, alu_rt, shamt);
   always_comb {nt_overflow, nt_alu_out} = alu_model(nt_alu_control, nt_alu_rs, nt_alu_rt, nt_shamt);

   // Architectural MIPS result for one instruction, independent of the encoding.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [5:0]  op, fn;
      logic [4:0]  sh;
      logic [31:0] se, ze, r;
      logic        wrap;
      op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'b0, ins[15:0]};
      r = '0; wrap = 1'b0;
      e.ri = 1'b0;
      e.dest = (op == 6'h00) ? ins[15:11] : ins[20:16];
      if (op == 6'h00) begin
         case (fn)
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = 32'($signed(b) >>> sh);
            6'h04: r = b << a[4:0];
            6'h06: r = b >> a[4:0];
            6'h07: r = 32'($signed(b) >>> a[4:0]);
            6'h20: begin r = a + b; wrap = (a[31] == b[31]) && (r[31] != a[31]); end
            6'h21: r = a + b;
            6'h22: begin r = a - b; wrap = (a[31] != b[31]) && (r[31] != a[31]); end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = {31'b0, $signed(a) < $signed(b)};
            6'h2B: r = {31'b0, a < b};
            default: e.ri = 1'b1;
         endcase
      end else begin
         case (op)
            6'h08: begin r = a + se; wrap = (a[31] == se[31]) && (r[31] != a[31]); end
            6'h09: r = a + se;
            6'h0A: r = {31'b0, $signed(a) < $signed(se)};
            6'h0B: r = {31'b0, a < se};
            6'h0C: r = a & ze;
            6'h0D: r = a | ze;
            6'h0E: r = a ^ ze;
            6'h0F: r = {ins[15:0], 16'b0};
            default: e.ri = 1'b1;
         endcase
      end
      e.data  = e.ri ? 32'h0 : r;
      e.ovf   = wrap;
      e.we    = !e.ri && !wrap && (e.dest != 5'd0);
      e.we_nt = !e.ri;
      return e;
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [4:0] sh);
      return {6'h00, s, t, d, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      bit done;
      done = 1'b0;
      @(negedge clk);
      instr = ins; rs_val = a; rt_val = b; in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (in_ready) begin
            sb.push_back(model(ins, a, b));
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) check("accept_timeout", 96'd0, 96'd1);
      #1 in_valid = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_wb_valid"}, {95'd0, wb_valid}, 96'd0);
      check({tag, "_in_ready"}, {95'd0, in_ready}, 96'd1);
      check({tag, "_alu"}, {22'd0, alu_rs, alu_rt, alu_control, shamt}, 96'd0);
      check({tag, "_wb"}, {56'd0, wb_data, wb_dest, wb_we, exc_ovf, exc_ri}, 96'd0);
   endtask

   // Retire monitor, sampling mid-cycle after inputs have settled.
   initial begin : monitor
      logic        prev_stall;
      logic [39:0] prev_rec;
      exp_t        e;
      prev_stall = 1'b0;
      prev_rec   = '0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", {95'd0, wb_valid}, 96'd1);
               check("hold_rec", {56'd0, wb_data, wb_dest, wb_we, exc_ovf, exc_ri}, {56'd0, prev_rec});
            end
            if (wb_valid && wb_ready) begin
               if (sb.size() == 0) begin
                  check("retire_unexpected", 96'd1, 96'd0);
               end else begin
                  e = sb.pop_front();
                  check("wb_data", {64'd0, wb_data}, {64'd0, e.data});
                  if (!e.ri) check("wb_dest", {91'd0, wb_dest}, {91'd0, e.dest});
                  check("wb_flags", {93'd0, wb_we, exc_ovf, exc_ri}, {93'd0, e.we, e.ovf, e.ri});
                  check("nt_valid", {95'd0, nt_wb_valid}, 96'd1);
                  check("nt_data", {64'd0, nt_wb_data}, {64'd0, e.data});
                  check("nt_flags", {93'd0, nt_wb_we, nt_exc_ovf, nt_exc_ri}, {93'd0, e.we_nt, 1'b0, e.ri});
               end
            end
            prev_stall = wb_valid && !wb_ready;
            prev_rec   = {wb_data, wb_dest, wb_we, exc_ovf, exc_ri};
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] t_i [18];
      logic [31:0] t_a [18];
      logic [31:0] t_b [18];
      t_i = '{rtype(6'h22,1,2,8,0), rtype(6'h22,1,2,9,0), rtype(6'h23,1,2,10,0), rtype(6'h24,1,2,11,0),
              rtype(6'h25,1,2,12,0), rtype(6'h26,1,2,13,0), rtype(6'h27,1,2,14,0), rtype(6'h2A,1,2,15,0),
              rtype(6'h2B,1,2,16,0), rtype(6'h00,0,2,17,4), rtype(6'h02,0,2,18,4), rtype(6'h03,0,2,19,4),
              rtype(6'h07,1,2,20,0), itype(6'h08,1,21,16'h0001), itype(6'h0A,1,22,16'h8000),
              itype(6'h0C,1,23,16'hF0F0), itype(6'h0D,1,24,16'h00F0), itype(6'h0E,1,25,16'hFFFF)};
      t_a = '{32'd10, 32'h80000000, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'h00000021, 32'h7FFFFFFF, 32'd0,
              32'hFFFFFFFF, 32'h12345600, 32'h0000FFFF};
      t_b = '{32'd3, 32'd1, 32'd10, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
              32'd1, 32'd1, 32'h80000001, 32'h80000000, 32'h80000000, 32'h80000000, 32'd0, 32'd0,
              32'd0, 32'd0, 32'd0};

      rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
      instr = '0; rs_val = '0; rt_val = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1 check_cleared("reset");

      send(rtype(6'h21, 1, 2, 3, 0), 32'd5, 32'd7);
      check("addu_ctrl", {91'd0, alu_control}, 96'd7);
      @(posedge clk);
      #1;
      check("addu_wb_valid", {95'd0, wb_valid}, 96'd1);
      check("addu_wb_data", {64'd0, wb_data}, 96'd12);

      send(rtype(6'h20, 1, 2, 4, 0), 32'h7FFFFFFF, 32'd1);
      send(rtype(6'h04, 1, 2, 5, 0), 32'h00000024, 32'd1);
      check("sllv_mask", {64'd0, alu_rs}, 96'd4);
      send(itype(6'h0F, 0, 6, 16'hABCD), 32'h12345678, 32'h5555);
      send(itype(6'h0B, 1, 7, 16'hFFFF), 32'd5, 32'd0);
      for (int i = 0; i < 18; i++) send(t_i[i], t_a[i], t_b[i]);
      send(itype(6'h23, 1, 9, 16'h0010), 32'd4, 32'd4);
      send(rtype(6'h18, 1, 2, 9, 0), 32'd4, 32'd4);
      send(rtype(6'h21, 1, 2, 0, 0), 32'd1, 32'd2);
      repeat (5) @(negedge clk);
      check("drain_basic", 96'(sb.size()), 96'd0);

      // Stall: the second stage blocks for three cycles with a stream queued.
      wb_ready = 1'b0;
      send(rtype(6'h21, 1, 2, 1, 0), 32'd100, 32'd1);
      send(rtype(6'h23, 1, 2, 2, 0), 32'd100, 32'd1);
      fork
         begin repeat (3) @(negedge clk); wb_ready = 1'b1; end
      join_none
      @(negedge clk);
      #1 check("stall_in_ready", {95'd0, in_ready}, 96'd0);
      send(rtype(6'h26, 1, 2, 3, 0), 32'hAAAA, 32'h5555);
      send(itype(6'h09, 1, 4, 16'hFFFE), 32'd10, 32'd0);
      repeat (6) @(negedge clk);
      check("drain_stream", 96'(sb.size()), 96'd0);

      // Reset with both stages occupied discards them.
      wb_ready = 1'b0;
      send(rtype(6'h21, 1, 2, 5, 0), 32'd1, 32'd1);
      send(rtype(6'h21, 1, 2, 6, 0), 32'd2, 32'd2);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      #1 check_cleared("midrst");
      sb.delete();
      wb_ready = 1'b1;
      send(rtype(6'h21, 1, 2, 7, 0), 32'd20, 32'd22);
      repeat (4) @(negedge clk);
      check("drain_post_rst", 96'(sb.size()), 96'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
